// File: rtl/cpl_tlp_arbiter_pkg.sv
// Shared types and widths for the completion TLP arbiter slice.
`ifndef TLP_DATA_WIDTH
`define TLP_DATA_WIDTH 256
`endif
`ifndef TLP_STRB_WIDTH
`define TLP_STRB_WIDTH 8
`endif
`ifndef TLP_HDR_WIDTH
`define TLP_HDR_WIDTH 128
`endif

package pcie_cpl_pkg;
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_LOCK = 1'b1
  } arb_state_e;

  localparam int PKT_CNT_W  = 16;
  localparam int TLP_DATA_W = `TLP_DATA_WIDTH;
  localparam int TLP_STRB_W = `TLP_STRB_WIDTH;
  localparam int TLP_HDR_W  = `TLP_HDR_WIDTH;
endpackage

// File: rtl/cpl_tlp_arbiter_if.sv
// Completion TLP stream bundle; LANES > 1 packs one lane per source at slice i.
interface cpl_tlp_if
  import pcie_cpl_pkg::*;
#(
  parameter int LANES      = 1,
  parameter int DATA_WIDTH = TLP_DATA_W,
  parameter int STRB_WIDTH = TLP_STRB_W,
  parameter int HDR_WIDTH  = TLP_HDR_W
);
  logic [LANES*DATA_WIDTH-1:0] data;
  logic [LANES*STRB_WIDTH-1:0] strb;
  logic [LANES*HDR_WIDTH-1:0]  hdr;
  logic [LANES-1:0]            valid;
  logic [LANES-1:0]            sop;
  logic [LANES-1:0]            eop;
  logic [LANES-1:0]            ready;

  modport master (output data, strb, hdr, valid, sop, eop, input ready);
  modport slave  (input data, strb, hdr, valid, sop, eop, output ready);
endinterface

// File: rtl/cpl_tlp_arbiter_rr.sv
// Combinational round-robin pick: first requester strictly after last_grant, wrapping.
module rr_arbiter #(
  parameter int PORTS = 2,
  localparam int SEL_W = $clog2(PORTS)
) (
  input  logic [PORTS-1:0] req,
  input  logic [SEL_W-1:0] last_grant,
  output logic [SEL_W-1:0] grant,
  output logic             any_grant
);
  logic [SEL_W-1:0] idx;

  // Scan from the farthest offset down so the nearest requester is written last.
  always_comb begin
    grant     = '0;
    any_grant = 1'b0;
    idx       = '0;
    for (int i = PORTS; i >= 1; i--) begin
      idx = SEL_W'((int'(last_grant) + i) % PORTS);
      if (req[idx]) begin
        grant     = idx;
        any_grant = 1'b1;
      end
    end
  end
endmodule

// File: rtl/cpl_tlp_arbiter.sv
// Packet-atomic round-robin mux of completion TLP sources onto one registered tx channel.
module cpl_tlp_arbiter
  import pcie_cpl_pkg::*;
#(
  parameter int PORTS      = 2,
  parameter int DATA_WIDTH = TLP_DATA_W,
  parameter int STRB_WIDTH = TLP_STRB_W,
  parameter int HDR_WIDTH  = TLP_HDR_W,
  localparam int SEL_W     = $clog2(PORTS)
) (
  input  logic                 clk,
  input  logic                 rst,
  cpl_tlp_if.slave             in_cpl_tlp,
  cpl_tlp_if.master            tx_cpl_tlp,
  output logic [SEL_W-1:0]     grant_sel,
  output logic                 busy,
  output logic                 proto_err,
  output logic [PKT_CNT_W-1:0] pkt_count
);
  localparam logic [0:0] IDLE = 1'(ST_IDLE);
  localparam logic [0:0] LOCK = 1'(ST_LOCK);

  logic [DATA_WIDTH-1:0] data_arr [PORTS];
  logic [STRB_WIDTH-1:0] strb_arr [PORTS];
  logic [HDR_WIDTH-1:0]  hdr_arr  [PORTS];

  for (genvar p = 0; p < PORTS; p++) begin : g_unpack
    assign data_arr[p] = in_cpl_tlp.data[p*DATA_WIDTH +: DATA_WIDTH];
    assign strb_arr[p] = in_cpl_tlp.strb[p*STRB_WIDTH +: STRB_WIDTH];
    assign hdr_arr[p]  = in_cpl_tlp.hdr[p*HDR_WIDTH +: HDR_WIDTH];
  end

  logic [0:0]            state_p0;
  logic [SEL_W-1:0]      last_grant_p0;
  logic                  first_beat_p0;
  logic [DATA_WIDTH-1:0] data_p1;
  logic [STRB_WIDTH-1:0] strb_p1;
  logic [HDR_WIDTH-1:0]  hdr_p1;
  logic                  vld_p1, sop_p1, eop_p1;
  logic [PKT_CNT_W-1:0]  pkt_cnt_p1;

  logic [PORTS-1:0] eligible, stray, ready_c;
  logic [SEL_W-1:0] arb_grant;
  logic             arb_any, stage_ready, accept, perr_c;

  assign eligible    = in_cpl_tlp.valid & in_cpl_tlp.sop;
  assign stray       = in_cpl_tlp.valid & ~in_cpl_tlp.sop;
  assign stage_ready = !vld_p1 || tx_cpl_tlp.ready;

  rr_arbiter #(.PORTS(PORTS)) u_rr (
    .req        (eligible),
    .last_grant (last_grant_p0),
    .grant      (arb_grant),
    .any_grant  (arb_any)
  );

  // Headless beats in IDLE are swallowed so a broken source cannot wedge the channel.
  always_comb begin
    ready_c = '0;
    accept  = 1'b0;
    perr_c  = 1'b0;
    if (state_p0 == IDLE) begin
      ready_c = stray;
      perr_c  = |stray;
    end else begin
      ready_c[grant_sel] = stage_ready;
      accept = in_cpl_tlp.valid[grant_sel] & stage_ready;
      perr_c = accept & in_cpl_tlp.sop[grant_sel] & !first_beat_p0;
    end
  end

  assign in_cpl_tlp.ready = rst ? '0 : ready_c;
  assign proto_err        = !rst && perr_c;
  assign busy             = (state_p0 == LOCK);
  assign pkt_count        = pkt_cnt_p1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_p0      <= IDLE;
      last_grant_p0 <= SEL_W'(PORTS - 1);
      grant_sel     <= '0;
      first_beat_p0 <= 1'b0;
      data_p1       <= '0;
      strb_p1       <= '0;
      hdr_p1        <= '0;
      vld_p1        <= 1'b0;
      sop_p1        <= 1'b0;
      eop_p1        <= 1'b0;
      pkt_cnt_p1    <= '0;
    end else begin
      // p0 -> p1: accepted beat lands in the output register.
      if (accept) begin
        data_p1 <= data_arr[grant_sel];
        strb_p1 <= strb_arr[grant_sel];
        hdr_p1  <= hdr_arr[grant_sel];
        sop_p1  <= in_cpl_tlp.sop[grant_sel];
        eop_p1  <= in_cpl_tlp.eop[grant_sel];
        vld_p1  <= 1'b1;
      end else if (tx_cpl_tlp.ready) begin
        vld_p1  <= 1'b0;
      end

      if (vld_p1 && tx_cpl_tlp.ready && eop_p1)
        pkt_cnt_p1 <= pkt_cnt_p1 + PKT_CNT_W'(1);

      case (state_p0)
        IDLE: begin
          if (arb_any) begin
            grant_sel     <= arb_grant;
            first_beat_p0 <= 1'b1;
            state_p0      <= LOCK;
          end
        end
        default: begin
          if (accept) begin
            first_beat_p0 <= 1'b0;
            if (in_cpl_tlp.eop[grant_sel]) begin
              last_grant_p0 <= grant_sel;
              state_p0      <= IDLE;
            end
          end
        end
      endcase
    end
  end

  assign tx_cpl_tlp.data  = data_p1;
  assign tx_cpl_tlp.strb  = strb_p1;
  assign tx_cpl_tlp.hdr   = hdr_p1;
  assign tx_cpl_tlp.valid = vld_p1;
  assign tx_cpl_tlp.sop   = sop_p1;
  assign tx_cpl_tlp.eop   = eop_p1;
endmodule

// File: tb/tb_cpl_tlp_arbiter.sv
// Bench for cpl_tlp_arbiter: queued packet sources, packet-level round-robin reference, tx scoreboard.
module tb_cpl_tlp_arbiter;
  localparam int PORTS = 3;
  localparam int DW    = 64;
  localparam int SW    = 2;
  localparam int HW    = 32;
  localparam int SEL_W = $clog2(PORTS);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cpl_tlp_if #(.LANES(PORTS), .DATA_WIDTH(DW), .STRB_WIDTH(SW), .HDR_WIDTH(HW)) in_if ();
  cpl_tlp_if #(.LANES(1),     .DATA_WIDTH(DW), .STRB_WIDTH(SW), .HDR_WIDTH(HW)) tx_if ();

  logic [SEL_W-1:0] grant_sel;
  logic             busy, proto_err;
  logic [15:0]      pkt_count;

  cpl_tlp_arbiter #(.PORTS(PORTS), .DATA_WIDTH(DW), .STRB_WIDTH(SW), .HDR_WIDTH(HW)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_cpl_tlp (in_if),
    .tx_cpl_tlp (tx_if),
    .grant_sel  (grant_sel),
    .busy       (busy),
    .proto_err  (proto_err),
    .pkt_count  (pkt_count)
  );

  typedef struct packed {
    logic [DW-1:0] data;
    logic [SW-1:0] strb;
    logic [HW-1:0] hdr;
    logic          sop;
    logic          eop;
  } beat_t;

  beat_t src_q [PORTS][$];
  beat_t exp_q [$];

  int checks = 0, passes = 0, fails = 0;
  int cyc = 0, perr_cnt = 0, tx_beats = 0, first_tx = -1, exp_pkts = 0;
  int model_last = PORTS - 1;
  logic         prev_stall = 1'b0;
  logic [127:0] prev_snap = '0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] key(input beat_t b);
    return 128'({b.data, b.strb, (b.sop ? b.hdr : {HW{1'b0}}), b.sop, b.eop});
  endfunction

  function automatic beat_t tx_beat();
    beat_t b;
    b.data = tx_if.data; b.strb = tx_if.strb; b.hdr = tx_if.hdr;
    b.sop  = tx_if.sop[0]; b.eop = tx_if.eop[0];
    return b;
  endfunction

  function automatic bit src_empty();
    for (int p = 0; p < PORTS; p++) if (src_q[p].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic add_pkt(input int p, input int nb, input bit bad_mid = 1'b0);
    beat_t b;
    for (int i = 0; i < nb; i++) begin
      b.data = {$urandom, $urandom};
      b.strb = SW'($urandom);
      b.hdr  = HW'($urandom);
      b.sop  = (i == 0) || (bad_mid && i == 1);
      b.eop  = (i == nb - 1);
      src_q[p].push_back(b);
    end
  endtask

  // Reference: whole packets leave in round-robin order over ports that still hold packets.
  task automatic plan();
    int rd [PORTS];
    int found, p;
    beat_t b;
    for (int i = 0; i < PORTS; i++) rd[i] = 0;
    while (1) begin
      found = -1;
      for (int i = 1; i <= PORTS; i++) begin
        p = (model_last + i) % PORTS;
        if (found < 0 && rd[p] < src_q[p].size()) found = p;
      end
      if (found < 0) break;
      do begin
        b = src_q[found][rd[found]];
        rd[found]++;
        exp_q.push_back(b);
      end while (!b.eop && rd[found] < src_q[found].size());
      exp_pkts++;
      model_last = found;
    end
  endtask

  task automatic drive();
    for (int p = 0; p < PORTS; p++) begin
      beat_t b;
      b = '0;
      if (src_q[p].size() > 0) b = src_q[p][0];
      in_if.valid[p] = (src_q[p].size() > 0);
      in_if.sop[p]   = b.sop;
      in_if.eop[p]   = b.eop;
      in_if.data[p*DW +: DW] = b.data;
      in_if.strb[p*SW +: SW] = b.strb;
      in_if.hdr[p*HW +: HW]  = b.hdr;
    end
  endtask

  task automatic cycle(input bit nxt_rdy);
    logic [PORTS-1:0] acc, mask;
    beat_t e;
    @(negedge clk);
    cyc++;
    if (proto_err) perr_cnt++;
    if (prev_stall) chk("tx_hold", 128'(tx_beat()), prev_snap);
    if (busy) begin
      mask = '0;
      mask[grant_sel] = 1'b1;
      chk("ready_exclusive", 128'(in_if.ready & ~mask), 128'd0);
    end
    if (tx_if.valid[0] && tx_if.ready[0]) begin
      tx_beats++;
      if (first_tx < 0) first_tx = cyc;
      if (exp_q.size() == 0) chk("extra_tx_beat", 128'(exp_q.size()), 128'd1);
      else begin
        e = exp_q.pop_front();
        chk("tx_beat", key(tx_beat()), key(e));
      end
    end
    acc        = in_if.valid & in_if.ready;
    prev_stall = tx_if.valid[0] & !tx_if.ready[0];
    prev_snap  = 128'(tx_beat());
    @(posedge clk);
    #1;
    for (int p = 0; p < PORTS; p++) if (acc[p]) void'(src_q[p].pop_front());
    drive();
    tx_if.ready[0] = nxt_rdy;
  endtask

  task automatic drain(input int budget, input int prob);
    int n;
    n = 0;
    while ((exp_q.size() > 0 || !src_empty() || tx_if.valid[0]) && n < budget) begin
      cycle($urandom_range(99) < prob);
      n++;
    end
    chk("drain_in_budget", 128'(n < budget), 128'd1);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int start, n;
    logic [15:0] base;
    rst = 1'b1;
    in_if.valid = '0; in_if.sop = '0; in_if.eop = '0;
    in_if.data = '0; in_if.strb = '0; in_if.hdr = '0;
    tx_if.ready = '0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_tx_valid", 128'(tx_if.valid), 128'd0);
    chk("rst_in_ready", 128'(in_if.ready), 128'd0);
    chk("rst_grant_sel", 128'(grant_sel), 128'd0);
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_proto_err", 128'(proto_err), 128'd0);
    chk("rst_pkt_count", 128'(pkt_count), 128'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    tx_if.ready[0] = 1'b1;

    // Single 3-beat packet, latency and count
    add_pkt(0, 3); plan(); drive();
    start = cyc + 1; first_tx = -1; tx_beats = 0;
    drain(50, 100);
    chk("first_beat_latency", 128'(first_tx - start), 128'd2);
    chk("three_beats", 128'(tx_beats), 128'd3);
    chk("pkt_count_one", 128'(pkt_count), 128'd1);

    // Two ports with back-to-back single-beat packets alternate
    base = pkt_count;
    for (int k = 0; k < 4; k++) begin add_pkt(0, 1); add_pkt(1, 1); end
    plan(); drive();
    drain(200, 100);
    chk("alternate_pkts", 128'(16'(pkt_count - base)), 128'd8);

    // Long packet on port1 locks out a waiting port0
    add_pkt(1, 4); add_pkt(0, 2); plan(); drive();
    drain(100, 100);
    chk("lockout_exp_empty", 128'(exp_q.size()), 128'd0);

    // Downstream stall mid-packet
    base = pkt_count;
    add_pkt(0, 4); plan(); drive();
    tx_beats = 0; n = 0;
    while (tx_beats < 1 && n < 20) begin cycle(1'b1); n++; end
    for (int k = 0; k < 5; k++) begin
      cycle(1'b0);
      #1;
      chk("stall_in_ready", 128'(in_if.ready[0]), 128'd0);
      chk("stall_tx_valid", 128'(tx_if.valid), 128'd1);
    end
    drain(100, 100);
    chk("stall_pkt_count", 128'(16'(pkt_count - base)), 128'd1);

    // Headless beat in IDLE is dropped with a single error pulse
    begin
      beat_t rogue;
      rogue = '0; rogue.data = {$urandom, $urandom};
      src_q[0].push_back(rogue);
    end
    perr_cnt = 0; tx_beats = 0;
    drive(); #1;
    chk("rogue_proto_err", 128'(proto_err), 128'd1);
    chk("rogue_ready", 128'(in_if.ready[0]), 128'd1);
    for (int k = 0; k < 3; k++) cycle(1'b1);
    chk("rogue_perr_once", 128'(perr_cnt), 128'd1);
    chk("rogue_no_tx", 128'(tx_beats), 128'd0);
    chk("rogue_tx_idle", 128'(tx_if.valid), 128'd0);
    chk("rogue_consumed", 128'(src_q[0].size()), 128'd0);

    // Stray sop inside a packet is flagged and forwarded as a continuation
    perr_cnt = 0;
    add_pkt(0, 3, 1'b1); plan(); drive();
    drain(50, 100);
    chk("midsop_perr", 128'(perr_cnt), 128'd1);

    // Async reset mid-packet; the tail is abandoned and port0 gets first turn
    add_pkt(1, 4); plan(); drive();
    tx_beats = 0; n = 0;
    while (tx_beats < 1 && n < 20) begin cycle(1'b1); n++; end
    chk("reset_setup_reached", 128'(tx_beats), 128'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst_tx_valid", 128'(tx_if.valid), 128'd0);
    chk("arst_in_ready", 128'(in_if.ready), 128'd0);
    chk("arst_busy", 128'(busy), 128'd0);
    chk("arst_pkt_count", 128'(pkt_count), 128'd0);
    chk("arst_grant_sel", 128'(grant_sel), 128'd0);
    exp_q.delete();
    for (int p = 0; p < PORTS; p++) src_q[p].delete();
    drive();
    prev_stall = 1'b0;
    model_last = PORTS - 1;
    @(posedge clk); #1;
    rst = 1'b0;
    add_pkt(1, 2); add_pkt(0, 2); plan(); drive();
    tx_beats = 0;
    drain(100, 100);
    chk("post_reset_beats", 128'(tx_beats), 128'd4);
    chk("post_reset_pkts", 128'(pkt_count), 128'd2);

    // Randomized traffic with random backpressure
    perr_cnt = 0;
    for (int r = 0; r < 8; r++) begin
      base = pkt_count;
      exp_pkts = 0;
      for (int p = 0; p < PORTS; p++) begin
        n = $urandom_range(0, 3);
        for (int k = 0; k < n; k++) add_pkt(p, $urandom_range(1, 4));
      end
      plan(); drive();
      drain(2000, 70);
      chk("rand_pkt_count", 128'(16'(pkt_count - base)), 128'(exp_pkts));
    end
    chk("rand_no_proto_err", 128'(perr_cnt), 128'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/cpl_tlp_arbiter.md
Name: cpl_tlp_arbiter

Overview:
- Shares the single-segment PCIe completion TLP transmit channel (tx_cpl_tlp_*) between PORTS completion sources, e.g. AXI-read completion generator and unsupported-request/error completer.
- Packet-atomic round-robin: once a port wins at SOP it owns the channel until its EOP beat is accepted.
- Single registered output stage; sits between the completion sources and the PCIe core TX completion interface.

Parameters:
- PORTS, 2, number of completion sources (2..8)
- DATA_WIDTH, 256, TLP payload width per beat (`TLP_DATA_WIDTH)
- STRB_WIDTH, 8, dword strobe width (`TLP_STRB_WIDTH)
- HDR_WIDTH, 128, TLP header width (`TLP_HDR_WIDTH)
- SEL_W, $clog2(PORTS), grant index width (derived, not overridable)

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous reset, active-high
- in_cpl_tlp_data  input  PORTS*DATA_WIDTH  per-port payload, port i at slice i
- in_cpl_tlp_strb  input  PORTS*STRB_WIDTH  per-port dword strobes
- in_cpl_tlp_hdr  input  PORTS*HDR_WIDTH  per-port header, valid on SOP beat
- in_cpl_tlp_valid  input  PORTS  per-port beat valid
- in_cpl_tlp_sop  input  PORTS  per-port start of packet
- in_cpl_tlp_eop  input  PORTS  per-port end of packet
- in_cpl_tlp_ready  output  PORTS  per-port ready
- tx_cpl_tlp_data  output  DATA_WIDTH  to PCIe core
- tx_cpl_tlp_strb  output  STRB_WIDTH  to PCIe core
- tx_cpl_tlp_hdr  output  HDR_WIDTH  to PCIe core
- tx_cpl_tlp_valid  output  1  to PCIe core
- tx_cpl_tlp_sop  output  1  to PCIe core
- tx_cpl_tlp_eop  output  1  to PCIe core
- tx_cpl_tlp_ready  input  1  from PCIe core
- grant_sel  output  SEL_W  currently/last granted port
- busy  output  1  FSM in LOCK
- proto_err  output  1  one-cycle pulse per protocol violation
- pkt_count  output  16  packets delivered on tx (EOP accepted), wraps 0xFFFF->0

Behaviour:
- Reset (async assert, sync-to-clk release): all tx_* outputs 0, in_cpl_tlp_ready 0, state IDLE, last_grant=PORTS-1 (port 0 first priority), grant_sel 0, busy 0, proto_err 0, pkt_count 0. Reset mid-packet abandons the packet; no partial beat is later emitted.
- stage_ready = !tx_cpl_tlp_valid || tx_cpl_tlp_ready (combinational).
- IDLE: eligible = valid & sop. If any eligible, pick first eligible index after last_grant (wrapping), register grant_sel, go LOCK. No beat transfers from eligible ports in IDLE (1-cycle arbitration bubble per packet).
- IDLE, port with valid & !sop: ready=1, beat discarded, proto_err=1 that cycle (prevents hang); such ports are not eligible.
- LOCK: in_cpl_tlp_ready[grant_sel]=stage_ready; all others 0. Accepted beat (valid&ready) is registered into tx_* next edge (latency 1). Accepted beat with eop -> last_grant=grant_sel, IDLE. sop=1 on a non-first beat -> proto_err pulse, beat forwarded as continuation, no re-arbitration.
- Single-beat packet (sop&eop): IDLE->LOCK->IDLE, minimum 2 cycles per packet per port.
- Output stage: tx_* held stable while valid & !ready; cleared valid when ready and no new beat accepted. hdr forwarded every beat, meaningful only when tx sop=1.
- pkt_count increments when tx_cpl_tlp_valid & ready & eop.
- Simultaneous SOP on all ports: strict rotation, no port granted twice before each other requester served once.

Decomposition:
- Shared package pcie_cpl_pkg: state enum (IDLE, LOCK), PKT_CNT_W=16; widths taken from define.sv macros.
- One sub-module: rr_arbiter (PORTS request vector, last_grant in, grant index + any_grant out, purely combinational).

Test Plan:
- Port0 sends 3-beat packet, tx_ready=1 -> tx shows sop,beat,eop on 3 consecutive cycles starting 2 cycles after valid; pkt_count=1.
- Ports 0 and 1 both hold 1-beat packets continuously for 8 packets -> tx sequence 0,1,0,1,... alternating; pkt_count=8.
- Port1 mid-packet (beat 2 of 4), port0 asserts sop -> port0 ready stays 0 until port1 eop accepted; no interleaving on tx.
- tx_ready deasserted 5 cycles mid-packet -> tx data/hdr/sop/eop stable, granted in_ready 0, no beat lost or duplicated.
- Port0 valid without sop in IDLE -> beat dropped, proto_err pulses exactly once, tx_valid stays 0; next sop packet forwards normally.
- rst asserted during beat 2 of 4 -> outputs 0 immediately (async), after release port0 wins first and the abandoned packet tail is never emitted.
